// File: rtl/ir_nec_receiver.sv
// NEC IR front end: synchronizes the receiver pin, measures pulse widths in
// ticks and assembles 32-bit frames, flagging repeat codes and timing errors.
module ir_nec_receiver #(
    parameter int CLKS_PER_TICK = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_rx,
    output logic [31:0] IR_code,
    output logic        latch,
    output logic        rpt,
    output logic        err,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_TICK - 1);
    localparam logic [10:0] DUR_MAX     = 11'd2047;
    localparam logic [10:0] TIMEOUT     = 11'd1100;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LEAD_LOW  = 3'd1,
        LEAD_HIGH = 3'd2,
        BIT_LOW   = 3'd3,
        BIT_HIGH  = 3'd4,
        STOP_LOW  = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic          sync_1, sync_2, rx_prev;
    logic          fall, rise, edge_seen, tick;
    logic [PW-1:0] presc;
    logic [10:0]   dur;
    logic [31:0]   shreg, shreg_nxt;
    logic [5:0]    bits, bits_nxt;
    logic          rep, rep_nxt;
    logic          have_frame, have_nxt;
    logic          load_code, set_latch, set_rpt, set_err, bad;
    logic          latch_pend, rpt_pend;

    function automatic logic in_win(input logic [10:0] d, input logic [10:0] lo,
                                    input logic [10:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    assign fall      = rx_prev & ~sync_2;
    assign rise      = ~rx_prev & sync_2;
    assign edge_seen = fall | rise;
    assign tick      = (presc == PRESC_MAX);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1  <= 1'b1;
            sync_2  <= 1'b1;
            rx_prev <= 1'b1;
            presc   <= '0;
            dur     <= '0;
        end else begin
            sync_1  <= ir_rx;
            sync_2  <= sync_1;
            rx_prev <= sync_2;
            // Both counters restart on every edge so each pulse is timed from zero.
            if (edge_seen || tick) presc <= '0;
            else                   presc <= presc + 1'b1;
            if (edge_seen)                     dur <= '0;
            else if (tick && dur != DUR_MAX)   dur <= dur + 11'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        bits_nxt  = bits;
        rep_nxt   = rep;
        have_nxt  = have_frame;
        load_code = 1'b0;
        set_latch = 1'b0;
        set_rpt   = 1'b0;
        set_err   = 1'b0;
        bad       = 1'b0;
        case (state)
            IDLE: begin
                if (fall) state_nxt = LEAD_LOW;
            end
            LEAD_LOW: begin
                if (rise && in_win(dur, 11'd800, 11'd1000)) state_nxt = LEAD_HIGH;
                else if (edge_seen)                         bad = 1'b1;
            end
            LEAD_HIGH: begin
                if (fall && in_win(dur, 11'd400, 11'd500)) begin
                    state_nxt = BIT_LOW;
                    bits_nxt  = '0;
                    rep_nxt   = 1'b0;
                end else if (fall && in_win(dur, 11'd180, 11'd270)) begin
                    state_nxt = STOP_LOW;
                    rep_nxt   = 1'b1;
                end else if (edge_seen) begin
                    bad = 1'b1;
                end
            end
            BIT_LOW: begin
                if (rise && in_win(dur, 11'd40, 11'd75)) state_nxt = BIT_HIGH;
                else if (edge_seen)                      bad = 1'b1;
            end
            BIT_HIGH: begin
                if (fall && (in_win(dur, 11'd40, 11'd75) || in_win(dur, 11'd140, 11'd200))) begin
                    shreg_nxt = {shreg[30:0], in_win(dur, 11'd140, 11'd200)};
                    bits_nxt  = bits + 6'd1;
                    state_nxt = (bits == 6'd31) ? STOP_LOW : BIT_LOW;
                end else if (edge_seen) begin
                    bad = 1'b1;
                end
            end
            STOP_LOW: begin
                if (rise && in_win(dur, 11'd40, 11'd75)) begin
                    state_nxt = IDLE;
                    if (!rep) begin
                        load_code = 1'b1;
                        set_latch = 1'b1;
                        have_nxt  = 1'b1;
                    end else if (have_frame) begin
                        set_rpt = 1'b1;
                    end else begin
                        set_err = 1'b1;
                    end
                end else if (edge_seen) begin
                    bad = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && !edge_seen && dur >= TIMEOUT) bad = 1'b1;
        if (bad) begin
            state_nxt = IDLE;
            set_err   = 1'b1;
            have_nxt  = 1'b0;
        end
    end

    // latch/rpt are delayed one extra cycle so IR_code is stable a full clock first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bits       <= '0;
            rep        <= 1'b0;
            have_frame <= 1'b0;
            IR_code    <= '0;
            latch_pend <= 1'b0;
            rpt_pend   <= 1'b0;
            latch      <= 1'b0;
            rpt        <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bits       <= bits_nxt;
            rep        <= rep_nxt;
            have_frame <= have_nxt;
            if (load_code) IR_code <= shreg;
            latch_pend <= set_latch;
            rpt_pend   <= set_rpt;
            latch      <= latch_pend;
            rpt        <= rpt_pend;
            err        <= set_err;
        end
    end

endmodule

// File: tb/tb_ir_nec_receiver.sv
// Bench for ir_nec_receiver: drives NEC waveforms with randomized widths and
// checks latch/rpt/err pulses and IR_code against a frame-level model.
module tb_ir_nec_receiver;

    localparam int CPT = 2;
    localparam int GAP = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        ir_rx;
    logic [31:0] IR_code;
    logic        latch, rpt, err, busy;
    logic [2:0]  state_dbg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int err_cyc = 0;

    // Expected pulse: {latch, rpt, err, IR_code}
    logic [34:0] exp_q[$];
    logic [31:0] model_code = '0;
    logic        model_have = 1'b0;
    logic [31:0] prev_code;

    ir_nec_receiver #(.CLKS_PER_TICK(CPT)) dut (
        .clk(clk), .reset(reset), .ir_rx(ir_rx), .IR_code(IR_code),
        .latch(latch), .rpt(rpt), .err(err), .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Frame-level model
    task automatic expect_data(input logic [31:0] code);
        model_code = code;
        model_have = 1'b1;
        exp_q.push_back({3'b100, code});
    endtask

    task automatic expect_repeat();
        if (model_have) exp_q.push_back({3'b010, model_code});
        else            exp_q.push_back({3'b001, model_code});
    endtask

    task automatic expect_error();
        model_have = 1'b0;
        exp_q.push_back({3'b001, model_code});
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (latch || rpt || err) begin
                if (err) err_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {latch, rpt, err}, 3'b000);
                end else begin
                    logic [34:0] e;
                    e = exp_q.pop_front();
                    check("pulse_kind", {latch, rpt, err}, e[34:32]);
                    check("ir_code_at_pulse", IR_code, e[31:0]);
                    if (latch) check("ir_code_setup", prev_code, e[31:0]);
                end
            end
        end
        prev_code = IR_code;
    end

    function automatic int win(input int lo);
        return int'($urandom_range(lo + 12, lo + 3));
    endfunction

    task automatic seg(input logic lvl, input int ticks);
        ir_rx = lvl;
        repeat (ticks * CPT) @(negedge clk);
    endtask

    task automatic leader(input int space_lo);
        seg(1'b0, win(800));
        seg(1'b1, win(space_lo));
    endtask

    task automatic send_bits(input logic [31:0] code, input int nbits, input int bad_at);
        for (int i = 0; i < nbits; i++) begin
            seg(1'b0, win(40));
            if (i == bad_at)       seg(1'b1, 100);
            else if (code[31 - i]) seg(1'b1, win(140));
            else                   seg(1'b1, win(40));
        end
    endtask

    task automatic send_data(input logic [31:0] code);
        expect_data(code);
        leader(400);
        send_bits(code, 32, -1);
        seg(1'b0, win(40));
        seg(1'b1, GAP);
    endtask

    task automatic send_repeat();
        expect_repeat();
        leader(180);
        seg(1'b0, win(40));
        seg(1'b1, GAP);
    endtask

    task automatic send_short_leader();
        expect_error();
        seg(1'b0, 700);
        seg(1'b1, GAP);
        check("short_busy", busy, 1'b0);
        check("short_state_idle", state_dbg, 3'd0);
    endtask

    task automatic send_bad_bit(input logic [31:0] code, input int pos);
        expect_error();
        leader(400);
        send_bits(code, pos + 1, pos);
        seg(1'b0, win(40));
        seg(1'b1, GAP);
    endtask

    task automatic settle(input string tag);
        repeat (20) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int fall_cyc;
        reset = 1'b1;
        ir_rx = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_code", IR_code, 32'h0);
        check("rst_pulses", {latch, rpt, err}, 3'b000);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        send_repeat();
        settle("repeat_no_frame");
        send_short_leader();
        settle("short_leader");

        send_data(32'hB857E02F);
        settle("frame_b857");
        check("code_b857", IR_code, 32'hB857E02F);
        send_repeat();
        settle("repeat_after_frame");
        check("code_after_repeat", IR_code, 32'hB857E02F);

        send_bad_bit(32'h00FF30CF, 12);
        settle("bad_bit12");
        send_data(32'h00FF30CF);
        settle("frame_00ff");
        check("code_00ff", IR_code, 32'h00FF30CF);

        leader(400);
        send_bits(32'h12345678, 20, -1);
        seg(1'b0, 20);
        reset = 1'b1;
        ir_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_code", IR_code, 32'h0);
        check("midrst_pulses", {latch, rpt, err}, 3'b000);
        check("midrst_busy", busy, 1'b0);
        reset = 1'b0;
        model_code = '0;
        model_have = 1'b0;
        repeat (GAP * CPT) @(negedge clk);
        settle("midrst_quiet");
        send_repeat();
        settle("repeat_after_reset");

        expect_error();
        leader(400);
        send_bits(32'hA5A5A5A5, 5, -1);
        fall_cyc = cyc;
        seg(1'b0, 1200);
        check("stuck_busy", busy, 1'b0);
        check("stuck_err_seen", exp_q.size(), 0);
        check("stuck_timeout_window",
              ((err_cyc - fall_cyc) >= 1100 * CPT) && ((err_cyc - fall_cyc) <= 1100 * CPT + 12), 1'b1);
        seg(1'b1, GAP);
        settle("stuck_quiet");

        for (int k = 0; k < 3; k++) begin
            case ($urandom_range(2, 0))
                0:       send_repeat();
                1:       send_short_leader();
                default: send_bad_bit($urandom, int'($urandom_range(7, 0)));
            endcase
            settle("random_scenario");
            check("random_code_hold", IR_code, model_code);
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
